// File: rtl/attention_residual_add_pkg.sv
// Shared sizing, Q8.8 saturation limits, FSM encoding and the saturating adder.
// Combinational helpers only; no timing or flow control here.
package attention_residual_add_pkg;

  localparam int unsigned SEQ_LEN   = 30;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PTR_W     = 5;
  localparam int unsigned OUT_DEPTH = 4;

  localparam logic [PTR_W-1:0]  SEQ_END = PTR_W'(SEQ_LEN);
  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_COMBINE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Sign-extend by one bit; the two top bits differ exactly when the 16-bit result would wrap.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? SAT_MIN : SAT_MAX;
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/attention_residual_add_if.sv
// Token/attention input streams and valid/ready sum output stream.
// Inputs carry no backpressure; only data_out honours data_out_ready.
interface attention_residual_add_if import attention_residual_add_pkg::*; ();

  logic [DATA_W-1:0] x_in;
  logic              x_in_valid;
  logic [DATA_W-1:0] attn_in;
  logic              attn_in_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_ready;

  modport slave (
    input  x_in, x_in_valid, attn_in, attn_in_valid, data_out_ready,
    output data_out, data_out_valid
  );

  modport master (
    output x_in, x_in_valid, attn_in, attn_in_valid, data_out_ready,
    input  data_out, data_out_valid
  );

endinterface

// File: rtl/attention_residual_add_sync_fifo.sv
// Small synchronous FIFO with synchronous clear; head is visible combinationally, 0 when empty.
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= push_dat;
  end

endmodule

// File: rtl/attention_residual_add.sv
// Pairs each attention result with its buffered residual token and streams the saturated sum.
// attn_in -> data_out_valid is 2 cycles; sums arriving at a full, non-draining FIFO are dropped.
module attention_residual_add import attention_residual_add_pkg::*; (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  attention_residual_add_if.slave   bus,
  output logic                      frame_done,
  output logic                      err_underrun,
  output logic                      err_overflow
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, out_cnt_q, out_cnt_d;
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              sum_vld_q, sum_vld_d;
  logic              err_under_q, err_under_d, err_ovf_q, err_ovf_d;
  logic [DATA_W-1:0] res_buf [SEQ_LEN];

  logic active, wr_en, rd_req, rd_hit;
  logic fifo_full, fifo_empty, fifo_pop;

  assign active   = !frame_start && (state_q != ST_DONE);
  assign wr_en    = active && bus.x_in_valid && (wr_ptr_q < SEQ_END);
  assign rd_req   = active && bus.attn_in_valid && (rd_ptr_q < SEQ_END);
  // Compared against the registered write pointer, so a same-cycle write cannot satisfy the read.
  assign rd_hit   = rd_req && (rd_ptr_q < wr_ptr_q);
  assign fifo_pop = !fifo_empty && bus.data_out_ready;

  assign bus.data_out_valid = !fifo_empty;
  assign frame_done         = fifo_pop && (out_cnt_q == SEQ_END - 1'b1);
  assign err_underrun       = err_under_q;
  assign err_overflow       = err_ovf_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_cnt_d   = out_cnt_q;
    state_d     = state_q;
    sum_d       = sum_q;
    sum_vld_d   = 1'b0;
    err_under_d = err_under_q;
    err_ovf_d   = err_ovf_q;
    if (frame_start) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_cnt_d   = '0;
      state_d     = ST_FILL;
      err_under_d = 1'b0;
      err_ovf_d   = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_hit) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        sum_d     = sat_add(bus.attn_in, res_buf[rd_ptr_q]);
        sum_vld_d = 1'b1;
      end
      if (rd_req && !rd_hit) err_under_d = 1'b1;
      if (sum_vld_q && fifo_full && !fifo_pop) err_ovf_d = 1'b1;
      if (fifo_pop) out_cnt_d = out_cnt_q + 1'b1;
      case (state_q)
        ST_FILL:    if (rd_hit) state_d = ST_COMBINE;
        ST_COMBINE: if (rd_ptr_q == SEQ_END) state_d = ST_DRAIN;
        ST_DRAIN:   if (out_cnt_q == SEQ_END) state_d = ST_DONE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_cnt_q   <= '0;
      state_q     <= ST_FILL;
      sum_q       <= '0;
      sum_vld_q   <= 1'b0;
      err_under_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_cnt_q   <= out_cnt_d;
      state_q     <= state_d;
      sum_q       <= sum_d;
      sum_vld_q   <= sum_vld_d;
      err_under_q <= err_under_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) res_buf[wr_ptr_q] <= bus.x_in;
  end

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (frame_start),
    .push     (sum_vld_q),
    .push_dat (sum_q),
    .pop      (fifo_pop),
    .pop_dat  (bus.data_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_attention_residual_add.sv
// Directed bench: table of residual/attention/expected-sum records plus multi-cycle corner sequences.
module tb_attention_residual_add;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic frame_done, err_underrun, err_overflow;

  attention_residual_add_if bus ();

  attention_residual_add dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .bus          (bus.slave),
    .frame_done   (frame_done),
    .err_underrun (err_underrun),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] attn;
    logic [15:0] sum;
  } vec_t;

  vec_t vec [8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx(input int mode, input int i);
    return (mode == 0) ? 0 : (i % 8);
  endfunction

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic load_x(input int mode);
    for (int i = 0; i < 30; i++) begin
      bus.x_in       = vec[idx(mode, i)].x;
      bus.x_in_valid = 1'b1;
      tick();
    end
    bus.x_in_valid = 1'b0;
  endtask

  // Full frame with ready held high: output j must be visible exactly 2 cycles after attn j.
  task automatic run_frame(input int mode);
    int done_cnt;
    done_cnt = 0;
    pulse_start();
    load_x(mode);
    bus.data_out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      bus.attn_in_valid = (c < 30);
      bus.attn_in       = vec[idx(mode, c)].attn;
      tick();
      check("out_valid", {31'd0, bus.data_out_valid}, {31'd0, (c >= 1 && c <= 30)});
      if (c >= 1 && c <= 30)
        check("out_data", {16'd0, bus.data_out}, {16'd0, vec[idx(mode, c - 1)].sum});
      if (frame_done) done_cnt++;
      check("frame_done", {31'd0, frame_done}, {31'd0, (c == 30)});
    end
    bus.attn_in_valid = 1'b0;
    check("frame_done_count", done_cnt, 1);
    check("err_underrun_clean", {31'd0, err_underrun}, 0);
    check("err_overflow_clean", {31'd0, err_overflow}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    vec[0] = '{16'h0100, 16'h0080, 16'h0180};
    vec[1] = '{16'h7F00, 16'h0200, 16'h7FFF};
    vec[2] = '{16'h8100, 16'h8000, 16'h8000};
    vec[3] = '{16'hFF00, 16'h0100, 16'h0000};
    vec[4] = '{16'h7FFF, 16'h0001, 16'h7FFF};
    vec[5] = '{16'h8000, 16'hFFFF, 16'h8000};
    vec[6] = '{16'h0001, 16'hFFFF, 16'h0000};
    vec[7] = '{16'hC000, 16'h2000, 16'hE000};

    bus.x_in = '0;
    bus.x_in_valid = 1'b0;
    bus.attn_in = '0;
    bus.attn_in_valid = 1'b0;
    bus.data_out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", {31'd0, bus.data_out_valid}, 0);
    check("rst_data", {16'd0, bus.data_out}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    check("rst_underrun", {31'd0, err_underrun}, 0);
    check("rst_overflow", {31'd0, err_overflow}, 0);
    rst_n = 1'b1;
    tick();

    // Uniform frame, then saturation patterns cycled across a frame
    run_frame(0);
    run_frame(1);

    // Overflow: ready low, five sums into a four-deep FIFO
    pulse_start();
    load_x(1);
    bus.data_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.attn_in_valid = 1'b1;
      bus.attn_in       = vec[i].attn;
      tick();
    end
    bus.attn_in_valid = 1'b0;
    tick();
    tick();
    check("ovf_flag", {31'd0, err_overflow}, 1);
    check("ovf_valid", {31'd0, bus.data_out_valid}, 1);
    check("ovf_head", {16'd0, bus.data_out}, {16'd0, vec[0].sum});
    tick();
    tick();
    check("ovf_head_stable", {16'd0, bus.data_out}, {16'd0, vec[0].sum});
    check("ovf_no_underrun", {31'd0, err_underrun}, 0);
    bus.data_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", {31'd0, bus.data_out_valid}, 1);
      check("drain_data", {16'd0, bus.data_out}, {16'd0, vec[k].sum});
      tick();
    end
    check("drain_empty", {31'd0, bus.data_out_valid}, 0);

    // Underrun: attn with nothing buffered, then same-cycle write and read
    pulse_start();
    bus.attn_in_valid = 1'b1;
    bus.attn_in       = 16'h0080;
    tick();
    bus.attn_in_valid = 1'b0;
    check("udr_flag", {31'd0, err_underrun}, 1);
    tick();
    tick();
    check("udr_no_output", {31'd0, bus.data_out_valid}, 0);
    pulse_start();
    check("udr_cleared", {31'd0, err_underrun}, 0);
    bus.x_in_valid    = 1'b1;
    bus.x_in          = 16'h0100;
    bus.attn_in_valid = 1'b1;
    bus.attn_in       = 16'h0080;
    tick();
    bus.x_in_valid    = 1'b0;
    bus.attn_in_valid = 1'b0;
    check("udr_same_cycle", {31'd0, err_underrun}, 1);
    tick();
    tick();
    check("udr_same_no_output", {31'd0, bus.data_out_valid}, 0);
    bus.attn_in_valid = 1'b1;
    bus.attn_in       = 16'h0080;
    tick();
    bus.attn_in_valid = 1'b0;
    check("udr_retry_latency", {31'd0, bus.data_out_valid}, 0);
    tick();
    check("udr_retry_valid", {31'd0, bus.data_out_valid}, 1);
    check("udr_retry_data", {16'd0, bus.data_out}, 32'h0180);
    tick();

    // Mid-frame abort after 12 accepted outputs
    pulse_start();
    load_x(0);
    bus.data_out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 13; c++) begin
      bus.attn_in_valid = 1'b1;
      bus.attn_in       = vec[0].attn;
      tick();
      if (bus.data_out_valid) seen++;
    end
    check("abort_seen", seen, 12);
    frame_start       = 1'b1;
    bus.x_in_valid    = 1'b1;
    bus.attn_in_valid = 1'b1;
    tick();
    frame_start       = 1'b0;
    bus.x_in_valid    = 1'b0;
    bus.attn_in_valid = 1'b0;
    check("abort_valid", {31'd0, bus.data_out_valid}, 0);
    check("abort_underrun", {31'd0, err_underrun}, 0);
    tick();
    tick();
    check("abort_no_stale", {31'd0, bus.data_out_valid}, 0);
    run_frame(1);

    // Asynchronous reset in the middle of combining
    pulse_start();
    load_x(1);
    bus.data_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.attn_in_valid = 1'b1;
      bus.attn_in       = vec[i].attn;
      tick();
    end
    bus.attn_in_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_valid", {31'd0, bus.data_out_valid}, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.data_out_valid}, 0);
    check("async_rst_data", {16'd0, bus.data_out}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", {31'd0, bus.data_out_valid}, 0);
    run_frame(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
